// File: rtl/gpio_pkg.sv
// gpio_pkg: shared types and constants for the GPIO pad controller.
//   DEB_CNT_WIDTH  - width of the per-pin debounce tick counter
//   gpio_pad_out_t - registered pad-drive bits for one pin (out/oen/ren)
//   gpio_edge_t    - rise/fall event pulses for one pin
package gpio_pkg;

   localparam int DEB_CNT_WIDTH = 4;

   typedef struct packed {
      logic out;   // pad i_i
      logic oen;   // pad oen_i, 1 = driver off
      logic ren;   // pad ren_i, 0 = pull on
   } gpio_pad_out_t;

   typedef struct packed {
      logic rise;
      logic fall;
   } gpio_edge_t;

endpackage

// File: rtl/gpio_pad_ctrl_if.sv
// gpio_pad_ctrl_if: pad-ring side of the GPIO bank.
//   pad_out_o / pad_oen_o / pad_ren_o : core -> pad cell drive pins
//   pad_in_i                          : pad cell c_o -> core (asynchronous)
// master = core controller, slave = pad ring.
interface gpio_pad_ctrl_if #(
   parameter int GPIO_NUM = 8
);
   logic [GPIO_NUM-1:0] pad_out_o;
   logic [GPIO_NUM-1:0] pad_oen_o;
   logic [GPIO_NUM-1:0] pad_ren_o;
   logic [GPIO_NUM-1:0] pad_in_i;

   modport master (output pad_out_o, pad_oen_o, pad_ren_o, input pad_in_i);
   modport slave  (input pad_out_o, pad_oen_o, pad_ren_o, output pad_in_i);
endinterface

// File: rtl/gpio_debounce.sv
// gpio_debounce: one pin's input path.
//   pad_in_i  - raw asynchronous pad input
//   tick_i    - shared prescaler tick (unused when debounce is compiled out)
//   stable_o  - filtered input value
//   edg_o     - rise/fall pulses of stable_o, one cycle each
// Macro GPIO_DEBOUNCE_EN: when defined, stable_o only follows the
// synchronized input after it has differed for DEB_THRESH ticks; when
// undefined, stable_o is the synchronized input delayed by one flop.
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int DEB_THRESH = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       tick_i,
   input  logic       pad_in_i,
   output logic       stable_o,
   output gpio_edge_t edg_o
);

   logic [1:0] sync_q, sync_d;
   logic       stable_q, stable_d;
   logic       prev_q, prev_d;

`ifdef GPIO_DEBOUNCE_EN
   logic [DEB_CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      sync_d   = {sync_q[0], pad_in_i};
      prev_d   = stable_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync_q[1] == stable_q) begin
         // any return to the filtered value restarts qualification
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == DEB_CNT_WIDTH'(DEB_THRESH - 1)) begin
            stable_d = sync_q[1];
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   logic unused_tick;
   assign unused_tick = tick_i;

   always_comb begin
      sync_d   = {sync_q[0], pad_in_i};
      prev_d   = stable_q;
      stable_d = sync_q[1];
   end
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         prev_q   <= prev_d;
      end
   end

   assign stable_o   = stable_q;
   assign edg_o.rise = stable_q & ~prev_q;
   assign edg_o.fall = ~stable_q & prev_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: core-side controller for a bank of tri-state GPIO pads.
//   clk_i, rst_n_i       - clock, async active-low reset
//   dir_i/out_i/pull_en_i- register-block pin configuration
//   deb_div_i            - debounce tick period minus 1
//   rise_en_i/fall_en_i  - per-pin edge interrupt enables
//   int_clr_i            - write-1-to-clear pending bits (set wins)
//   in_o                 - filtered pin inputs
//   int_pend_o, irq_o    - pending bits and their OR
//   pad_if (master)      - pad ring drive/sense pins
// Macro GPIO_DEBOUNCE_EN: enables the tick prescaler and per-pin glitch
// filter; without it deb_div_i is ignored.
module gpio_pad_ctrl
   import gpio_pkg::*;
#(
   parameter int GPIO_NUM      = 8,
   parameter int DEB_DIV_WIDTH = 16,
   parameter int DEB_THRESH    = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [GPIO_NUM-1:0]      dir_i,
   input  logic [GPIO_NUM-1:0]      out_i,
   input  logic [GPIO_NUM-1:0]      pull_en_i,
   input  logic [DEB_DIV_WIDTH-1:0] deb_div_i,
   input  logic [GPIO_NUM-1:0]      rise_en_i,
   input  logic [GPIO_NUM-1:0]      fall_en_i,
   input  logic [GPIO_NUM-1:0]      int_clr_i,
   output logic [GPIO_NUM-1:0]      in_o,
   output logic [GPIO_NUM-1:0]      int_pend_o,
   output logic                     irq_o,
   gpio_pad_ctrl_if.master          pad_if
);

   logic tick;

`ifdef GPIO_DEBOUNCE_EN
   logic [DEB_DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;

   // Compare on equality only: if deb_div_i drops below the count, the
   // counter runs to its maximum and wraps naturally.
   assign tick = (div_cnt_q == deb_div_i);

   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      if (tick) div_cnt_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) div_cnt_q <= '0;
      else          div_cnt_q <= div_cnt_d;
   end
`else
   logic unused_deb_div;
   assign unused_deb_div = ^deb_div_i;
   assign tick           = 1'b1;
`endif

   // ---------------- pad drive registers ----------------
   gpio_pad_out_t [GPIO_NUM-1:0] pad_q, pad_d;

   always_comb begin
      pad_d = pad_q;
      for (int i = 0; i < GPIO_NUM; i++) begin
         pad_d[i].out = out_i[i];
         pad_d[i].oen = ~dir_i[i];
         pad_d[i].ren = ~pull_en_i[i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // every pin an input with the driver and pull off
         for (int i = 0; i < GPIO_NUM; i++) begin
            pad_q[i] <= '{out: 1'b0, oen: 1'b1, ren: 1'b1};
         end
      end else begin
         pad_q <= pad_d;
      end
   end

   always_comb begin
      for (int i = 0; i < GPIO_NUM; i++) begin
         pad_if.pad_out_o[i] = pad_q[i].out;
         pad_if.pad_oen_o[i] = pad_q[i].oen;
         pad_if.pad_ren_o[i] = pad_q[i].ren;
      end
   end

   // ---------------- per-pin input path ----------------
   // Output-mode pins are sampled too, so loopback edges still interrupt.
   logic [GPIO_NUM-1:0]      stable;
   gpio_edge_t [GPIO_NUM-1:0] edg;

   for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
      gpio_debounce #(
         .DEB_THRESH (DEB_THRESH)
      ) u_deb (
         .clk_i    (clk_i),
         .rst_n_i  (rst_n_i),
         .tick_i   (tick),
         .pad_in_i (pad_if.pad_in_i[g]),
         .stable_o (stable[g]),
         .edg_o    (edg[g])
      );
   end

   // ---------------- interrupt pending ----------------
   logic [GPIO_NUM-1:0] rise, fall;
   logic [GPIO_NUM-1:0] int_pend_q, int_pend_d;

   always_comb begin
      rise = '0;
      fall = '0;
      for (int i = 0; i < GPIO_NUM; i++) begin
         rise[i] = edg[i].rise;
         fall[i] = edg[i].fall;
      end
      // a new event in the same cycle as a clear keeps the bit set
      int_pend_d = (int_pend_q & ~int_clr_i) | (rise & rise_en_i) | (fall & fall_en_i);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) int_pend_q <= '0;
      else          int_pend_q <= int_pend_d;
   end

   assign in_o       = stable;
   assign int_pend_o = int_pend_q;
   assign irq_o      = |int_pend_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
module tb_gpio_pad_ctrl;

   localparam int N = 8;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] dir, out, pull_en, rise_en, fall_en, int_clr;
   logic [W-1:0] deb_div;
   logic [N-1:0] in_o, int_pend;
   logic         irq;

   int checks   = 0;
   int failures = 0;

   gpio_pad_ctrl_if #(.GPIO_NUM(N)) pad_if ();

   gpio_pad_ctrl #(.GPIO_NUM(N), .DEB_DIV_WIDTH(W), .DEB_THRESH(4)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .dir_i      (dir),
      .out_i      (out),
      .pull_en_i  (pull_en),
      .deb_div_i  (deb_div),
      .rise_en_i  (rise_en),
      .fall_en_i  (fall_en),
      .int_clr_i  (int_clr),
      .in_o       (in_o),
      .int_pend_o (int_pend),
      .irq_o      (irq),
      .pad_if     (pad_if)
   );

   always #5 clk = ~clk;

   // advance one rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // wait for in_o[idx] == val; n = edges taken, or -1 if max expired
   task automatic wait_in(input int idx, input logic val, input int max, output int n);
      n = -1;
      for (int k = 1; k <= max; k++) begin
         step();
         if (in_o[idx] === val) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; dir = '0; out = '0; pull_en = '0; rise_en = '0; fall_en = '0;
      int_clr = '0; pad_if.pad_in_i = '0;
`ifdef GPIO_DEBOUNCE_EN
      deb_div = 16'd3;
`else
      deb_div = 16'hFFFF;
`endif
      #12;
      checks++; if (pad_if.pad_oen_o !== 8'hFF) begin failures++; $display("FAIL reset_oen got=%h exp=ff", pad_if.pad_oen_o); end
      checks++; if (pad_if.pad_ren_o !== 8'hFF) begin failures++; $display("FAIL reset_ren got=%h exp=ff", pad_if.pad_ren_o); end
      checks++; if (pad_if.pad_out_o !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", pad_if.pad_out_o); end
      checks++; if (in_o !== 8'h00) begin failures++; $display("FAIL reset_in got=%h exp=00", in_o); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
      checks++; if (int_pend !== 8'h00) begin failures++; $display("FAIL reset_pend got=%h exp=00", int_pend); end
      @(negedge clk); rst_n = 1'b1;
      step();
      dir = 8'h01; out = 8'h01; pull_en = 8'h05;
      checks++; if (pad_if.pad_oen_o !== 8'hFF) begin failures++; $display("FAIL oen_latency got=%h exp=ff", pad_if.pad_oen_o); end
      step();
      checks++; if (pad_if.pad_oen_o !== 8'hFE) begin failures++; $display("FAIL oen_drive got=%h exp=fe", pad_if.pad_oen_o); end
      checks++; if (pad_if.pad_out_o !== 8'h01) begin failures++; $display("FAIL out_drive got=%h exp=01", pad_if.pad_out_o); end
      checks++; if (pad_if.pad_ren_o !== 8'hFA) begin failures++; $display("FAIL ren_drive got=%h exp=fa", pad_if.pad_ren_o); end
      dir = '0; out = '0; pull_en = '0;
   endtask

`ifdef GPIO_DEBOUNCE_EN
   task automatic test_filter_glitch();
      logic seen;
      seen = 1'b0;
      pad_if.pad_in_i[0] = 1'b1;
      for (int k = 0; k < 36; k++) begin
         step();
         if (k == 11) pad_if.pad_in_i[0] = 1'b0;   // high for 12 cycles
         if (in_o[0]) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL glitch_reject got=%b exp=0", seen); end
   endtask

   task automatic test_filter_qualify();
      int n;
      pad_if.pad_in_i[0] = 1'b1;
      wait_in(0, 1'b1, 40, n);
      // 2 sync edges, then 4 ticks of period 4: edges 15..18
      checks++; if (n < 15 || n > 22) begin failures++; $display("FAIL qualify_rise edges got=%0d exp=15..22", n); end
      pad_if.pad_in_i[0] = 1'b0;
      wait_in(0, 1'b0, 40, n);
      checks++; if (n < 15 || n > 22) begin failures++; $display("FAIL qualify_fall edges got=%0d exp=15..22", n); end
   endtask
`endif

   task automatic test_edges();
      int n;
      rise_en = 8'h02; fall_en = 8'h00;
      pad_if.pad_in_i[1] = 1'b1;
      wait_in(1, 1'b1, 40, n);
      checks++; if (n < 0) begin failures++; $display("FAIL edge_rise_timeout got=%0d exp=>0", n); end
      checks++; if (int_pend !== 8'h00) begin failures++; $display("FAIL edge_pend_early got=%h exp=00", int_pend); end
      step();
      checks++; if (int_pend !== 8'h02) begin failures++; $display("FAIL edge_pend_set got=%h exp=02", int_pend); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL edge_irq got=%b exp=1", irq); end
      int_clr = 8'h02; step(); int_clr = 8'h00;
      checks++; if (int_pend !== 8'h00) begin failures++; $display("FAIL edge_clear got=%h exp=00", int_pend); end
      pad_if.pad_in_i[1] = 1'b0;
      wait_in(1, 1'b0, 40, n);
      checks++; if (n < 0) begin failures++; $display("FAIL edge_fall_timeout got=%0d exp=>0", n); end
      step(); step();
      checks++; if (int_pend !== 8'h00) begin failures++; $display("FAIL edge_fall_masked got=%h exp=00", int_pend); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_fall_irq got=%b exp=0", irq); end
   endtask

   task automatic test_clear_collision();
      int n;
      rise_en = 8'h02; fall_en = 8'h00;
      pad_if.pad_in_i[1] = 1'b1;
      wait_in(1, 1'b1, 40, n);
      checks++; if (n < 0) begin failures++; $display("FAIL coll_timeout got=%0d exp=>0", n); end
      int_clr = 8'h02;             // lands on the same edge as the set
      step();
      int_clr = 8'h00;
      checks++; if (int_pend[1] !== 1'b1) begin failures++; $display("FAIL coll_set_wins got=%b exp=1", int_pend[1]); end
      step();
      checks++; if (int_pend[1] !== 1'b1) begin failures++; $display("FAIL coll_hold got=%b exp=1", int_pend[1]); end
      int_clr = 8'h02; step(); int_clr = 8'h00;
      checks++; if (int_pend !== 8'h00) begin failures++; $display("FAIL lone_clear got=%h exp=00", int_pend); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL lone_clear_irq got=%b exp=0", irq); end
   endtask

`ifndef GPIO_DEBOUNCE_EN
   task automatic test_nodeb_pulse();
      logic [4:0] in_seq, pend_seq;
      rise_en = 8'h08; fall_en = 8'h08;
      pad_if.pad_in_i[3] = 1'b1;
      for (int e = 0; e < 5; e++) begin
         step();
         if (e == 0) pad_if.pad_in_i[3] = 1'b0;   // one-cycle pulse
         in_seq[e]   = in_o[3];
         pend_seq[e] = int_pend[3];
      end
      // edges 1..5: in_o pulses at edge 3; pending from edge 4 (fall keeps it)
      checks++; if (in_seq !== 5'b00100) begin failures++; $display("FAIL nodeb_in_seq got=%b exp=00100", in_seq); end
      checks++; if (pend_seq !== 5'b11000) begin failures++; $display("FAIL nodeb_pend_seq got=%b exp=11000", pend_seq); end
      int_clr = 8'h08; step(); step(); int_clr = 8'h00;
      checks++; if (int_pend !== 8'h00) begin failures++; $display("FAIL nodeb_clear got=%h exp=00", int_pend); end
   endtask
`endif

   task automatic test_async_reset();
      int n;
      rise_en = 8'h04; fall_en = 8'h00;
      pad_if.pad_in_i[2] = 1'b1;
      wait_in(2, 1'b1, 40, n);
      step();
      checks++; if (int_pend[2] !== 1'b1) begin failures++; $display("FAIL arst_pre_pend got=%b exp=1", int_pend[2]); end
      pad_if.pad_in_i[0] = 1'b1;     // start pin 0 qualifying
      dir = 8'h30; out = 8'h10; pull_en = 8'h01;
      step(); step(); step();
      #2 rst_n = 1'b0;               // mid-cycle, away from any edge
      #1;
      checks++; if (int_pend !== 8'h00) begin failures++; $display("FAIL arst_pend got=%h exp=00", int_pend); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq got=%b exp=0", irq); end
      checks++; if (in_o !== 8'h00) begin failures++; $display("FAIL arst_in got=%h exp=00", in_o); end
      checks++; if (pad_if.pad_oen_o !== 8'hFF) begin failures++; $display("FAIL arst_oen got=%h exp=ff", pad_if.pad_oen_o); end
      checks++; if (pad_if.pad_ren_o !== 8'hFF) begin failures++; $display("FAIL arst_ren got=%h exp=ff", pad_if.pad_ren_o); end
      checks++; if (pad_if.pad_out_o !== 8'h00) begin failures++; $display("FAIL arst_out got=%h exp=00", pad_if.pad_out_o); end
      @(negedge clk); rst_n = 1'b1;
      step();
      checks++; if (in_o !== 8'h00) begin failures++; $display("FAIL arst_requal got=%h exp=00", in_o); end
   endtask

   initial begin
      test_reset();
`ifdef GPIO_DEBOUNCE_EN
      test_filter_glitch();
      test_filter_qualify();
`endif
      test_edges();
      test_clear_collision();
`ifndef GPIO_DEBOUNCE_EN
      test_nodeb_pulse();
`endif
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
